// File: rtl/rcpa_scan_pkg.sv
// ============================================================================
// Module  : rcpa_scan_pkg
// Brief   : Shared types and constants for the RCPA error-distance scanner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rcpa_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_t;

   localparam logic [1:0] SEL_RCPA1 = 2'd0;
   localparam logic [1:0] SEL_RCPA2 = 2'd1;
   localparam logic [1:0] SEL_RCPA3 = 2'd2;
   localparam logic [1:0] SEL_EXACT = 2'd3;

   localparam int DRAIN_DEPTH = 2;

   // Maximal-length Fibonacci taps; bit p-1 set for tap position p.
   function automatic logic [63:0] lfsr_taps(input int width);
      logic [63:0] t;
      case (width)
         4:       t = 64'h0000_0000_0000_000C;
         6:       t = 64'h0000_0000_0000_0030;
         8:       t = 64'h0000_0000_0000_00B8;
         10:      t = 64'h0000_0000_0000_0240;
         12:      t = 64'h0000_0000_0000_0829;
         14:      t = 64'h0000_0000_0000_2015;
         16:      t = 64'h0000_0000_0000_D008;
         20:      t = 64'h0000_0000_0009_0000;
         24:      t = 64'h0000_0000_00E1_0000;
         32:      t = 64'h0000_0000_8020_0003;
         default: t = 64'h0000_0000_0000_0003;
      endcase
      return t;
   endfunction

endpackage

`default_nettype wire

// File: rtl/nBitRcpa1.sv
// ============================================================================
// Module  : nBitRcpa1
// Brief   : Approximate adder, low half OR-ed with no carry into the top half.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nBitRcpa1 #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum,
   output logic         fn
);
   localparam int K = N / 2;

   assign sum[K-1:0]      = a[K-1:0] | b[K-1:0];
   assign {fn, sum[N-1:K]} = {1'b0, a[N-1:K]} + {1'b0, b[N-1:K]};

endmodule

`default_nettype wire

// File: rtl/nBitRcpa2.sv
// ============================================================================
// Module  : nBitRcpa2
// Brief   : Approximate adder, low half OR-ed; top half carry-in = a&b of the
//           low half's MSB.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nBitRcpa2 #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum,
   output logic         fn
);
   localparam int K = N / 2;

   assign sum[K-1:0]       = a[K-1:0] | b[K-1:0];
   assign {fn, sum[N-1:K]} = {1'b0, a[N-1:K]} + {1'b0, b[N-1:K]}
                           + {{(N-K){1'b0}}, a[K-1] & b[K-1]};

endmodule

`default_nettype wire

// File: rtl/nBitRcpa3.sv
// ============================================================================
// Module  : nBitRcpa3
// Brief   : Approximate ripple adder; low-half cells take carry-out = a_i,
//           top half is exact. Requires N >= 4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nBitRcpa3 #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum,
   output logic         fn
);
   localparam int K = N / 2;

   logic [K-1:0] w_carry_lo;

   // Carry into low-half bit i is simply a[i-1].
   assign w_carry_lo       = {a[K-2:0], 1'b0};
   assign sum[K-1:0]       = a[K-1:0] ^ b[K-1:0] ^ w_carry_lo;
   assign {fn, sum[N-1:K]} = {1'b0, a[N-1:K]} + {1'b0, b[N-1:K]}
                           + {{(N-K){1'b0}}, a[K-1]};

endmodule

`default_nettype wire

// File: rtl/rcpa_ed_acc.sv
// ============================================================================
// Module  : rcpa_ed_acc
// Brief   : Error-distance accumulator: nonzero count, running sum, maximum.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rcpa_ed_acc #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         valid,
   input  logic [N:0]   ed,
   output logic [2*N:0] err_cnt,
   output logic [3*N:0] ed_sum,
   output logic [N:0]   ed_max
);
   localparam logic [2*N:0] c_cnt_one = {{(2*N){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
         ed_sum  <= '0;
         ed_max  <= '0;
      end else if (clr) begin
         err_cnt <= '0;
         ed_sum  <= '0;
         ed_max  <= '0;
      end else if (valid) begin
         if (ed != '0) begin
            err_cnt <= err_cnt + c_cnt_one;
         end
         ed_sum <= ed_sum + {{(2*N){1'b0}}, ed};
         if (ed > ed_max) begin
            ed_max <= ed;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rcpa_err_scanner.sv
// ============================================================================
// Module  : rcpa_err_scanner
// Brief   : Sweeps operand pairs through three approximate adders and
//           accumulates error-distance statistics for the selected one.
//           RCPA_SCAN_LFSR_EN adds an LFSR random-stimulus mode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rcpa_err_scanner
   import rcpa_scan_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         abort,
   input  logic [1:0]   sel,
`ifdef RCPA_SCAN_LFSR_EN
   input  logic         mode,
   input  logic [15:0]  num_pairs,
`endif
   output logic         busy,
   output logic         done,
   output logic [2*N:0] err_cnt,
   output logic [3*N:0] ed_sum,
   output logic [N:0]   ed_max
);
   localparam logic [N-1:0] c_one        = {{(N-1){1'b0}}, 1'b1};
   localparam logic [1:0]   c_drain_last = 2'(DRAIN_DEPTH - 1);

   scan_state_t r_state, w_next;
   logic [1:0]   r_sel;
   logic [N-1:0] r_a, r_b, w_a_step, w_b_step;
   logic         r_issue, w_last_pair, w_accept, w_abort, w_clr;
   logic [1:0]   r_drain_cnt;

   logic [N-1:0] w_sum1, w_sum2, w_sum3;
   logic         w_fn1, w_fn2, w_fn3;
   logic [N:0]   w_exact0, w_approx;

   logic         r_s1_valid, r_s1_last;
   logic [N-1:0] r_s1_a, r_s1_b;
   logic [N:0]   r_s1_approx, w_exact1, w_ed;
   logic         r_s2_valid;
   logic [N:0]   r_s2_ed;

   assign w_accept = (r_state == ST_IDLE) && start && !abort;
   assign w_abort  = abort && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
   assign w_clr    = w_accept || w_abort;

   assign w_a_step = r_a + c_one;
   assign w_b_step = (&r_a) ? (r_b + c_one) : r_b;

`ifdef RCPA_SCAN_LFSR_EN
   localparam logic [63:0]    c_taps_full = lfsr_taps(2 * N);
   localparam logic [2*N-1:0] c_taps      = c_taps_full[2*N-1:0];
   localparam logic [2*N-1:0] c_seed      = {{(2*N-1){1'b0}}, 1'b1};

   logic          r_mode;
   logic [15:0]   r_left;
   logic [2*N-1:0] w_lfsr_next;

   assign w_lfsr_next = {r_b[N-2:0], r_a, ^({r_b, r_a} & c_taps)};
   assign w_last_pair = r_mode ? (r_left == 16'd1) : ((&r_a) && (&r_b));
`else
   assign w_last_pair = (&r_a) && (&r_b);
`endif

   // Operand stream: one pair per RUN cycle until the last pair is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel   <= SEL_RCPA1;
         r_a     <= '0;
         r_b     <= '0;
         r_issue <= 1'b0;
`ifdef RCPA_SCAN_LFSR_EN
         r_mode  <= 1'b0;
         r_left  <= '0;
`endif
      end else if (w_abort) begin
         r_a     <= '0;
         r_b     <= '0;
         r_issue <= 1'b0;
      end else if (w_accept) begin
         r_sel   <= sel;
         r_issue <= 1'b1;
`ifdef RCPA_SCAN_LFSR_EN
         r_mode  <= mode;
         r_left  <= (num_pairs == 16'd0) ? 16'd1 : num_pairs;
         {r_b, r_a} <= mode ? c_seed : '0;
`else
         r_a     <= '0;
         r_b     <= '0;
`endif
      end else if (r_issue) begin
         if (w_last_pair) begin
            r_issue <= 1'b0;
         end else begin
`ifdef RCPA_SCAN_LFSR_EN
            r_left <= r_left - 16'd1;
            {r_b, r_a} <= r_mode ? w_lfsr_next : {w_b_step, w_a_step};
`else
            {r_b, r_a} <= {w_b_step, w_a_step};
`endif
         end
      end
   end

   nBitRcpa1 #(.N(N)) u_rcpa1 (.a(r_a), .b(r_b), .sum(w_sum1), .fn(w_fn1));
   nBitRcpa2 #(.N(N)) u_rcpa2 (.a(r_a), .b(r_b), .sum(w_sum2), .fn(w_fn2));
   nBitRcpa3 #(.N(N)) u_rcpa3 (.a(r_a), .b(r_b), .sum(w_sum3), .fn(w_fn3));

   assign w_exact0 = {1'b0, r_a} + {1'b0, r_b};

   always_comb begin
      w_approx = w_exact0;
      case (r_sel)
         SEL_RCPA1: w_approx = {w_fn1, w_sum1};
         SEL_RCPA2: w_approx = {w_fn2, w_sum2};
         SEL_RCPA3: w_approx = {w_fn3, w_sum3};
         SEL_EXACT: w_approx = w_exact0;
      endcase
   end

   assign w_exact1 = {1'b0, r_s1_a} + {1'b0, r_s1_b};
   assign w_ed     = (w_exact1 >= r_s1_approx) ? (w_exact1 - r_s1_approx)
                                               : (r_s1_approx - w_exact1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_last   <= 1'b0;
         r_s1_a      <= '0;
         r_s1_b      <= '0;
         r_s1_approx <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_ed     <= '0;
      end else begin
         r_s1_valid  <= r_issue && !w_abort;
         r_s1_last   <= w_last_pair;
         r_s1_a      <= r_a;
         r_s1_b      <= r_b;
         r_s1_approx <= w_approx;
         r_s2_valid  <= r_s1_valid && !w_abort;
         r_s2_ed     <= w_ed;
      end
   end

   rcpa_ed_acc #(.N(N)) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (w_clr),
      .valid   (r_s2_valid),
      .ed      (r_s2_ed),
      .err_cnt (err_cnt),
      .ed_sum  (ed_sum),
      .ed_max  (ed_max)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_next;
         r_drain_cnt <= (r_state == ST_DRAIN) ? (r_drain_cnt + 2'd1) : 2'd0;
      end
   end

   // RUN ends once the last pair has been captured into stage 1.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_next = ST_RUN;
         ST_RUN: begin
            if (w_abort)                        w_next = ST_IDLE;
            else if (r_s1_valid && r_s1_last)   w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_abort)                        w_next = ST_IDLE;
            else if (r_drain_cnt == c_drain_last) w_next = ST_DONE;
         end
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   assign busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign done = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_rcpa_err_scanner.sv
// ============================================================================
// Module  : tb_rcpa_err_scanner
// Brief   : Directed bench for rcpa_err_scanner (N=4 and N=8 instances);
//           LFSR-mode vectors are built when RCPA_SCAN_LFSR_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rcpa_err_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start4, abort4, busy4, done4;
   logic [1:0]  sel4;
   logic [8:0]  cnt4;
   logic [12:0] sum4;
   logic [4:0]  max4;
   logic        start8, abort8, busy8, done8;
   logic [1:0]  sel8;
   logic [16:0] cnt8;
   logic [24:0] sum8;
   logic [8:0]  max8;
`ifdef RCPA_SCAN_LFSR_EN
   logic        mode4, mode8;
   logic [15:0] np4, np8;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rcpa_err_scanner #(.N(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .sel(sel4),
`ifdef RCPA_SCAN_LFSR_EN
      .mode(mode4), .num_pairs(np4),
`endif
      .busy(busy4), .done(done4), .err_cnt(cnt4), .ed_sum(sum4), .ed_max(max4)
   );

   rcpa_err_scanner #(.N(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8), .sel(sel8),
`ifdef RCPA_SCAN_LFSR_EN
      .mode(mode8), .num_pairs(np8),
`endif
      .busy(busy8), .done(done8), .err_cnt(cnt8), .ed_sum(sum8), .ed_max(max8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Bit-serial reference of the approximate adders; returns {fn,sum}.
   function automatic int approx_model(input int s, input int a, input int b, input int n);
      int k, c, r, ai, bi;
      k = n / 2; c = 0; r = 0;
      if (s == 3) return a + b;
      for (int i = 0; i < n; i++) begin
         ai = (a >> i) & 1;
         bi = (b >> i) & 1;
         if (i < k) begin
            if (s == 2) begin
               r = r | ((ai ^ bi ^ c) << i);
               c = ai;
            end else begin
               r = r | ((ai | bi) << i);
               c = 0;
               if (s == 1 && i == k - 1) c = ai & bi;
            end
         end else begin
            r = r | ((ai ^ bi ^ c) << i);
            c = (ai & bi) | (c & (ai ^ bi));
         end
      end
      return r | (c << n);
   endfunction

   function automatic int ed_of(input int s, input int a, input int b, input int n);
      int ex, ap;
      ex = a + b;
      ap = approx_model(s, a, b, n);
      return (ex > ap) ? ex - ap : ap - ex;
   endfunction

   // Full N=4 scan from a negedge; optionally hammers start during the scan.
   task automatic run4(input logic [1:0] s, input bit rep, input string tag);
      int ec, es, em, ed, first, dones;
      ec = 0; es = 0; em = 0; first = 0; dones = 0;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            ed = ed_of(int'(s), a, b, 4);
            if (ed != 0) ec++;
            es += ed;
            if (ed > em) em = ed;
         end
      end
      sel4 = s; start4 = 1'b1;
      for (int cyc = 1; cyc <= 270; cyc++) begin
         @(posedge clk); @(negedge clk);
         start4 = rep ? (busy4 | done4) : 1'b0;
         sel4 = ~s;
         if (done4) begin
            dones++;
            if (first == 0) first = cyc;
         end
         if (cyc == 1) chk({tag, " busy@1"}, busy4, 1);
      end
      chk({tag, " done cycle"}, first, 260);
      chk({tag, " done count"}, dones, 1);
      chk({tag, " idle at end"}, busy4, 0);
      chk({tag, " err_cnt"}, cnt4, ec);
      chk({tag, " ed_sum"}, sum4, es);
      chk({tag, " ed_max"}, max4, em);
   endtask

   initial begin
      int first, dones, ec, es, em, ed;
      logic [15:0] s16;
      logic        fb;
      rst_n = 1'b0;
      start4 = 1'b0; abort4 = 1'b0; sel4 = 2'd0;
      start8 = 1'b0; abort8 = 1'b0; sel8 = 2'd0;
`ifdef RCPA_SCAN_LFSR_EN
      mode4 = 1'b0; mode8 = 1'b0; np4 = 16'd0; np8 = 16'd0;
`endif
      repeat (3) @(negedge clk);
      chk("rst busy4", busy4, 0);
      chk("rst done4", done4, 0);
      chk("rst cnt4", cnt4, 0);
      chk("rst sum4", sum4, 0);
      chk("rst max4", max4, 0);
      chk("rst busy8", busy8, 0);
      chk("rst done8", done8, 0);
      chk("rst cnt8", cnt8, 0);

      // Start presented together with reset release.
      rst_n = 1'b1;
      run4(2'd0, 1'b0, "sel0");
      run4(2'd1, 1'b0, "sel1");
      run4(2'd2, 1'b0, "sel2");
      run4(2'd2, 1'b1, "sel2 rep");

      // abort + start together in IDLE
      start4 = 1'b1; abort4 = 1'b1;
      @(posedge clk); @(negedge clk);
      start4 = 1'b0; abort4 = 1'b0;
      chk("abort+start busy", busy4, 0);

      // abort on RUN cycle 100
      sel4 = 2'd1; start4 = 1'b1;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         @(posedge clk); @(negedge clk);
         start4 = 1'b0;
      end
      chk("pre-abort busy", busy4, 1);
      abort4 = 1'b1;
      @(posedge clk); @(negedge clk);
      abort4 = 1'b0;
      chk("abort busy", busy4, 0);
      chk("abort cnt", cnt4, 0);
      chk("abort sum", sum4, 0);
      chk("abort max", max4, 0);
      dones = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(posedge clk); @(negedge clk);
         if (done4) dones++;
      end
      chk("abort no done", dones, 0);
      run4(2'd1, 1'b0, "post-abort");

      // N=8 exact reference: full exhaustive scan
      sel8 = 2'd3; start8 = 1'b1; first = 0; dones = 0;
      for (int cyc = 1; cyc <= 65550; cyc++) begin
         @(posedge clk); @(negedge clk);
         start8 = 1'b0;
         sel8 = 2'd0;
         if (done8) begin
            dones++;
            if (first == 0) first = cyc;
         end
      end
      chk("n8 done cycle", first, 65540);
      chk("n8 done count", dones, 1);
      chk("n8 err_cnt", cnt8, 0);
      chk("n8 ed_sum", sum8, 0);
      chk("n8 ed_max", max8, 0);

`ifdef RCPA_SCAN_LFSR_EN
      ec = 0; es = 0; em = 0; s16 = 16'h0001;
      for (int i = 0; i < 10; i++) begin
         ed = ed_of(0, int'(s16[7:0]), int'(s16[15:8]), 8);
         if (ed != 0) ec++;
         es += ed;
         if (ed > em) em = ed;
         fb = s16[15] ^ s16[14] ^ s16[12] ^ s16[3];
         s16 = {s16[14:0], fb};
      end
      mode8 = 1'b1; np8 = 16'd10; sel8 = 2'd0; start8 = 1'b1; first = 0; dones = 0;
      for (int cyc = 1; cyc <= 24; cyc++) begin
         @(posedge clk); @(negedge clk);
         start8 = 1'b0;
         if (done8) begin
            dones++;
            if (first == 0) first = cyc;
         end
      end
      mode8 = 1'b0;
      chk("lfsr done cycle", first, 14);
      chk("lfsr done count", dones, 1);
      chk("lfsr err_cnt", cnt8, ec);
      chk("lfsr ed_sum", sum8, es);
      chk("lfsr ed_max", max8, em);
`endif

      // Reset in the first DRAIN cycle
      sel4 = 2'd0; start4 = 1'b1;
      for (int cyc = 1; cyc <= 258; cyc++) begin
         @(posedge clk); @(negedge clk);
         start4 = 1'b0;
      end
      chk("drain busy", busy4, 1);
      rst_n = 1'b0;
      #1;
      chk("async rst busy", busy4, 0);
      chk("async rst cnt", cnt4, 0);
      chk("async rst sum", sum4, 0);
      chk("async rst max", max4, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      run4(2'd0, 1'b0, "post-reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rcpa_err_scanner.md
RCPA_ERR_SCANNER -- requirements
Module: rcpa_err_scanner

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the adder operand width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: single-cycle scan request, sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: terminates any scan in progress.
REQ-006 The block SHALL have port sel, input, 2 bits: adder under test; 0=nBitRcpa1, 1=nBitRcpa2, 2=nBitRcpa3, 3=exact reference.
REQ-007 The block SHALL have port busy, output, 1 bit: high in RUN and DRAIN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when a scan completes.
REQ-009 The block SHALL have port err_cnt, output, 2N+1 bits: count of pairs with nonzero error distance.
REQ-010 The block SHALL have port ed_sum, output, 3N+1 bits: sum of error distances.
REQ-011 The block SHALL have port ed_max, output, N+1 bits: largest error distance seen.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN, DRAIN and DONE: IDLE->RUN on start; RUN->DRAIN after the last pair issues; DRAIN->DONE after 2 cycles; DONE->IDLE unconditionally.
REQ-013 On start in IDLE the block SHALL latch sel, clear all three result outputs, and zero operands a and b.
REQ-014 The block SHALL feed the RUN operand stream, one pair per cycle, to the three approximate adders in parallel.
REQ-015 The RUN operand stream SHALL step a every cycle, step b when a wraps from all-ones to 0, and issue the last pair at a=b=all-ones, for 2^(2N) pairs in total.
REQ-016 The block SHALL form the exact result as the (N+1)-bit value a+b and the approximate result as {fn,sum} of the selected instance.
REQ-017 The block SHALL compute error distance as |exact - approx|, N+1 bits, unsigned.
REQ-018 The datapath SHALL be a 2-stage pipeline (stage 1: registered operands and approximate result; stage 2: registered error distance), followed by the accumulate step.
REQ-019 For sel=3 the block SHALL take the approximate result from the exact adder, so error distance is 0.
REQ-020 Accumulation SHALL follow these width rules: err_cnt += (ed!=0); ed_sum += ed; ed_max = max(ed_max, ed); none of these SHALL overflow over a full scan.
REQ-021 The block SHALL assert done for exactly one cycle, in DONE, at 2^(2N)+4 cycles after the cycle in which start was sampled.
REQ-022 The block SHALL hold the results stable from done until the next accepted start.
REQ-023 The block SHALL ignore start outside IDLE; a start asserted in the DONE cycle SHALL be lost, and the earliest accepted start SHALL be the following IDLE cycle.
REQ-024 abort in RUN or DRAIN SHALL cause IDLE on the next edge, no done, results cleared to 0, and pipeline valids flushed.
REQ-025 If abort and start are asserted together in IDLE, abort SHALL win and the scan SHALL not start.
REQ-026 The block SHALL change sel only at start; sel changes mid-scan SHALL have no effect.

Reset
REQ-027 rst_n low SHALL asynchronously force: state=IDLE, busy=0, done=0, err_cnt=0, ed_sum=0, ed_max=0, operands=0, pipeline valids=0.
REQ-028 Reset asserted mid-scan SHALL discard the scan, with no done pulse after release.
REQ-029 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 The block SHALL use the macro RCPA_SCAN_LFSR_EN to select random-stimulus mode.
REQ-031 With RCPA_SCAN_LFSR_EN defined, the block SHALL add inputs mode (1 bit) and num_pairs (16 bits), sampled at start.
REQ-032 With RCPA_SCAN_LFSR_EN defined and mode=1, the block SHALL take {b,a} from a 2N-bit maximal-length Fibonacci LFSR seeded with 1 at start, issue num_pairs pairs, and treat num_pairs=0 as 1 pair.
REQ-033 Without RCPA_SCAN_LFSR_EN, the mode and num_pairs ports SHALL be absent and the scan SHALL be exhaustive only, per REQ-015.

Structure
REQ-034 Package rcpa_scan_pkg SHALL hold: the FSM state enum, the sel encodings (SEL_RCPA1..SEL_EXACT), the DRAIN depth constant 2, and the LFSR tap table per N.
REQ-035 The block SHALL have one sub-module, rcpa_ed_acc: error distance in plus valid/clear in, giving err_cnt, ed_sum and ed_max.
REQ-036 The block SHALL instantiate nBitRcpa1, nBitRcpa2 and nBitRcpa3 directly, each with parameter N.

Verification
REQ-037 The bench SHALL cover: N=8, sel=3, start -> done at cycle 65540; err_cnt=0, ed_sum=0, ed_max=0.
REQ-038 The bench SHALL cover: N=4, sel=0..2 exhaustive -> results equal a bench scoreboard over all 256 pairs; done at cycle 260.
REQ-039 The bench SHALL cover: start repeated every cycle during RUN -> single scan, single done, results identical to the unrepeated run.
REQ-040 The bench SHALL cover: abort at cycle 100 of RUN -> busy=0 next cycle, no done, all results 0; a new start runs to full correct results.
REQ-041 The bench SHALL cover: rst_n low mid-DRAIN -> outputs 0 immediately (asynchronous), no done after release.
REQ-042 The bench SHALL cover: with RCPA_SCAN_LFSR_EN, mode=1, num_pairs=10, N=8 -> done at cycle 14; results match a scoreboard over the first 10 LFSR states.
